// File: rtl/strela_pkg.sv
// strela_pkg -- shared types and constants for the output memory node.
//
// Contents:
//   OMN_FIFO_DEPTH       entries in the write-data FIFO
//   OMN_MAX_OUTSTANDING  max OBI writes granted but not yet answered
//   OMN_OUT_W            width of the outstanding-write counter
//   omn_state_e          node FSM states
//   obi_req_t            OBI master request bundle
//   obi_resp_t           OBI response bundle (write-only node: handshake only)
//   eff_stride()         maps a zero stride to one word (4 bytes)
package strela_pkg;

   localparam int OMN_FIFO_DEPTH      = 4;
   localparam int OMN_MAX_OUTSTANDING = 4;
   localparam int OMN_OUT_W           = $clog2(OMN_MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MREQ,
      S_FLUSH,
      S_DONE
   } omn_state_e;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic gnt;
      logic rvalid;
   } obi_resp_t;

   // A zero stride would write every word to the same address; treat it
   // as a packed word stream instead.
   function automatic logic [15:0] eff_stride(input logic [15:0] stride);
      return (stride == 16'h0) ? 16'd4 : stride;
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3 -- synchronous first-word-registered FIFO.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous reset, active low
//   flush_i  synchronous clear of all entries
//   full_o   no room for a push
//   empty_o  nothing to pop
//   data_i   push data
//   push_i   push request (ignored while full)
//   data_o   head entry (valid while !empty_o)
//   pop_i    pop request (ignored while empty)
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_DEPTH-1:0] rptr, wptr;
   logic [ADDR_DEPTH:0]   cnt;
   logic                  push_ok, pop_ok;

   // Pointers wrap explicitly so non-power-of-two depths work too.
   function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
      return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + ADDR_DEPTH'(1);
   endfunction

   assign full_o  = (cnt == (ADDR_DEPTH + 1)'(DEPTH));
   assign empty_o = (cnt == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem[rptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else if (flush_i) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         if (push_ok) wptr <= ptr_inc(wptr);
         if (pop_ok)  rptr <= ptr_inc(rptr);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + (ADDR_DEPTH + 1)'(1);
            2'b01:   cnt <= cnt - (ADDR_DEPTH + 1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wptr] <= data_i;
   end

endmodule

// File: rtl/output_memory_node.sv
// output_memory_node -- drains a fabric data stream into memory over OBI.
//
// Words accepted on din_* are buffered in a small FIFO and written to
// output_addr_i + offset, the offset stepping by the (effective) stride,
// until output_size_i bytes of address space are covered. done_o rises once
// every granted write has been answered and holds until clr_i / rst_i.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous reset, active high
//   clr_i            synchronous clear, same effect as rst_i
//   exec_i           execution phase active
//   output_addr_i    byte base address of the output region
//   output_size_i    region size in bytes (0 = nothing to write)
//   output_stride_i  byte step per word (0 = 4)
//   masters_req_o    OBI write request
//   masters_resp_i   OBI grant / rvalid
//   din_i/din_v_i/din_r_o  fabric data stream (valid/ready)
//   done_o           all writes committed
//   stall_cycles_o   cycles with req high and gnt low
//
// Build option: define OMN_PERF_CNT_EN to build the stall counter;
// otherwise stall_cycles_o is tied to zero.
module output_memory_node
   import strela_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        exec_i,
   input  logic [31:0] output_addr_i,
   input  logic [15:0] output_size_i,
   input  logic [15:0] output_stride_i,
   output obi_req_t    masters_req_o,
   input  obi_resp_t   masters_resp_i,
   input  logic [31:0] din_i,
   input  logic        din_v_i,
   output logic        din_r_o,
   output logic        done_o,
   output logic [31:0] stall_cycles_o
);

   omn_state_e           state, state_nxt;
   logic                 clear;
   logic [15:0]          stride;
   logic [15:0]          in_offset, wr_offset;
   logic                 in_ovf;
   logic [16:0]          in_sum, wr_sum;
   logic                 last_word;
   logic [OMN_OUT_W-1:0] outstanding, out_nxt;
   logic                 fifo_full, fifo_empty;
   logic [31:0]          fifo_head;
   logic                 accept, req, grant, rvalid;

   assign clear  = rst_i | clr_i;
   assign stride = eff_stride(output_stride_i);
   assign rvalid = masters_resp_i.rvalid;

   // Offsets are 16-bit; the 17th sum bit is the carry, which counts as
   // being past the end of the region.
   assign in_sum    = {1'b0, in_offset} + {1'b0, stride};
   assign wr_sum    = {1'b0, wr_offset} + {1'b0, stride};
   assign last_word = wr_sum[16] | (wr_sum[15:0] >= output_size_i);

   // in_ovf remembers an input-offset carry so a wrapped offset can never
   // look like it is back inside the region.
   assign din_r_o = exec_i & ~fifo_full & (state == S_MREQ) & ~in_ovf
                    & (in_offset < output_size_i);
   assign accept  = din_v_i & din_r_o;

   assign req   = (state == S_MREQ) & ~fifo_empty
                  & (outstanding < OMN_OUT_W'(OMN_MAX_OUTSTANDING));
   assign grant = req & masters_resp_i.gnt;

   always_comb begin
      masters_req_o       = '0;
      masters_req_o.req   = req;
      masters_req_o.we    = 1'b1;
      masters_req_o.be    = 4'b1111;
      masters_req_o.addr  = output_addr_i + {16'h0, wr_offset};
      masters_req_o.wdata = fifo_head;
   end

   assign done_o = (state == S_DONE);

   // Outstanding writes. A response with nothing outstanding belongs to a
   // transaction abandoned by reset and is dropped (saturate at zero).
   always_comb begin
      out_nxt = outstanding;
      if (grant && !rvalid)
         out_nxt = outstanding + OMN_OUT_W'(1);
      else if (!grant && rvalid && (outstanding != '0))
         out_nxt = outstanding - OMN_OUT_W'(1);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (exec_i)
               state_nxt = (output_size_i != 16'h0) ? S_MREQ : S_DONE;
         end
         S_MREQ: begin
            if (grant && last_word) state_nxt = S_FLUSH;
         end
         // Looking at out_nxt lets done_o rise the cycle after the final
         // response rather than two cycles later.
         S_FLUSH: begin
            if ((out_nxt == '0) && !grant) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (clear) begin
         state       <= S_IDLE;
         in_offset   <= '0;
         in_ovf      <= 1'b0;
         wr_offset   <= '0;
         outstanding <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= out_nxt;
         if (accept) begin
            in_offset <= in_sum[15:0];
            if (in_sum[16]) in_ovf <= 1'b1;
         end
         if (grant) wr_offset <= wr_sum[15:0];
      end
   end

   // rst_i also drives the FIFO reset so a reset mid-burst drops buffered
   // words; clr_i uses the FIFO's own synchronous flush.
   fifo_v3 #(
      .DATA_WIDTH (32),
      .DEPTH      (OMN_FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (~rst_i),
      .flush_i (clr_i),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_i  (din_i),
      .push_i  (accept),
      .data_o  (fifo_head),
      .pop_i   (grant)
   );

`ifdef OMN_PERF_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk_i) begin
      if (clear)
         stall_cnt <= '0;
      else if (req && !masters_resp_i.gnt && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign stall_cycles_o = stall_cnt;
`else
   assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: doc/output_memory_node.md
OUTPUT_MEMORY_NODE -- requirements
Module: output_memory_node

Interface
REQ-001 SHALL have port clk_i, input, 1, single clock; all flops rise-edge.
REQ-002 SHALL have port rst_i, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have port clr_i, input, 1, synchronous clear, same effect as rst_i.
REQ-004 SHALL have port exec_i, input, 1, execution phase active.
REQ-005 SHALL have port output_addr_i, input, 32, byte base address.
REQ-006 SHALL have port output_size_i, input, 16, region size in bytes.
REQ-007 SHALL have port output_stride_i, input, 16, byte offset increment per word.
REQ-008 SHALL have port masters_req_o, output, obi_req_t, OBI master request.
REQ-009 SHALL have port masters_resp_i, input, obi_resp_t, OBI response.
REQ-010 SHALL have ports din_i (input, 32), din_v_i (input, 1) and din_r_o (output, 1), the data stream from the fabric.
REQ-011 SHALL have port done_o, output, 1, all writes committed.
REQ-012 SHALL have port stall_cycles_o, output, 32, perf counter (see Configuration).

Function
REQ-013 SHALL use FSM states S_IDLE, S_MREQ, S_FLUSH, S_DONE.
REQ-014 S_IDLE SHALL go to S_MREQ if exec_i and output_size_i!=0, to S_DONE if exec_i and output_size_i==0, else stay in S_IDLE.
REQ-015 SHALL accept data (din_v_i & din_r_o) into an OMN_FIFO_DEPTH-entry FIFO.
REQ-016 din_r_o SHALL be exec_i & !full & (state==S_MREQ) & (in_offset < output_size_i).
REQ-017 in_offset (16 bit) SHALL advance by the effective stride on each accept.
REQ-018 SHALL treat output_stride_i==0 as a stride of 4.
REQ-019 masters_req_o.req SHALL be (state==S_MREQ) & !empty & (outstanding < OMN_MAX_OUTSTANDING).
REQ-020 Request fields SHALL be: we=1, be=4'b1111, wdata=FIFO head, addr=output_addr_i+{16'h0,wr_offset}.
REQ-021 On grant (req & gnt) the FIFO SHALL pop, wr_offset SHALL advance by the stride, and outstanding SHALL increment.
REQ-022 Each masters_resp_i.rvalid SHALL decrement outstanding; a grant and rvalid in the same cycle SHALL leave it unchanged.
REQ-023 S_MREQ SHALL go to S_FLUSH on a grant where wr_offset+stride >= output_size_i.
REQ-024 S_FLUSH SHALL go to S_DONE when outstanding==0 and no grant is pending.
REQ-025 S_DONE SHALL be held until clr_i or rst_i; done_o = (state==S_DONE).
REQ-026 Offset arithmetic SHALL be 16-bit; a carry-out SHALL count as >= output_size_i.
REQ-027 With the FIFO full, din_r_o SHALL drop the same cycle, and no data SHALL be lost or duplicated.
REQ-028 Word order in memory SHALL equal acceptance order.

Reset
REQ-029 On rst_i or clr_i: state=S_IDLE; offsets, outstanding and FIFO cleared; req=0, din_r_o=0, done_o=0, stall_cycles_o=0.
REQ-030 Reset mid-burst SHALL abandon pending data and ignore responses to earlier grants that arrive later (outstanding saturates at 0).

Configuration
REQ-031 With OMN_PERF_CNT_EN defined, stall_cycles_o SHALL count cycles with req=1 and gnt=0, saturating at 32'hFFFFFFFF.
REQ-032 Without OMN_PERF_CNT_EN, stall_cycles_o SHALL be constant 0 and the counter SHALL not be built.

Structure
REQ-033 OMN_FIFO_DEPTH (4), OMN_MAX_OUTSTANDING (4) and the state enum type SHALL live in strela_pkg.
REQ-034 The FIFO SHALL be an instance of the existing fifo_v3 (flush_i=clr_i); there SHALL be no other sub-modules.

Verification
REQ-035 size=16, stride=4, gnt always 1, rvalid 1 cycle later, 4 words -> writes at base+0,4,8,12 in order; done_o one cycle after the last rvalid.
REQ-036 exec_i with size=0 -> S_DONE next cycle, no req issued, din_r_o never asserted.
REQ-037 gnt held low 10 cycles, 8 words offered -> din_r_o low after 4 accepted; stall_cycles_o=10 with the macro, 0 without.
REQ-038 rvalid withheld 20 cycles -> req stops at 4 outstanding; done_o only after the 4th rvalid.
REQ-039 size=12, stride=0 -> addresses base+0,4,8; din_r_o drops after the 3rd accept.
REQ-040 rst_i pulsed with 2 writes outstanding -> all outputs at reset values next cycle; late rvalids cause no underflow; a fresh run completes correctly.
